// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the full byte-enable mask.
package mem_ctrl_pkg;

  // Store size codes, as driven on cpu_wr_size (mem_write encoding)
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Load size codes, as driven on cpu_rd_size; also the internal access size
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_e;

  // Fold a store size code onto the load encoding so one size path serves both
  function automatic logic [1:0] st_to_ld(input logic [1:0] st_size);
    logic [1:0] sz;
    case (st_size)
      SZ_BYTE: sz = LD_BYTE;
      SZ_HALF: sz = LD_HALF;
      default: sz = LD_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: byte enables, store data replication, alignment check
// and load data extraction with sign/zero extension.
module lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = mem_rdata[{ld_lo, 3'b000} +: 8];
  assign ld_half = mem_rdata[{ld_lo[1], 4'b0000} +: 16];

  always_comb begin
    be         = BE_ALL;
    wdata      = req_wdata;
    misaligned = 1'b0;
    case (req_size)
      LD_BYTE: begin
        be    = 4'b0001 << req_lo;
        wdata = {4{req_wdata[7:0]}};
      end
      LD_HALF: begin
        be         = req_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{req_wdata[15:0]}};
        misaligned = req_lo[0];
      end
      default: misaligned = |req_lo;
    endcase
  end

  always_comb begin
    ld_data = mem_rdata;
    case (ld_size)
      LD_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      LD_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit: turns datapath memory accesses into req/ack bus cycles,
// stalling the CPU while a transfer is outstanding.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic [1:0]  cpu_rd_size,
  input  logic        cpu_rd_unsigned,
  input  logic [1:0]  cpu_wr_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_e state_q, state_d;

  logic             is_store, req;
  logic [1:0]       acc_size;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d, ld_data;
  logic             mis_d;
  logic             start, ack_hit, timeout_hit, mis_hit;

  logic             is_load_q, uns_q;
  logic [1:0]       size_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic             rdata_valid_q, misaligned_q, bus_error_q, mem_req_q, mem_we_q;

  // A store takes priority; cpu_rd is ignored whenever a store size is present
  assign is_store = (cpu_wr_size != SZ_NONE);
  assign req      = cpu_rd | is_store;
  assign acc_size = is_store ? st_to_ld(cpu_wr_size) :
                    (cpu_rd_size == 2'b11) ? LD_WORD : cpu_rd_size;

  lane_align u_lane_align (
    .req_size    (acc_size),
    .req_lo      (cpu_addr[1:0]),
    .req_wdata   (cpu_wdata),
    .be          (be_d),
    .wdata       (wdata_d),
    .misaligned  (mis_d),
    .ld_size     (size_q),
    .ld_lo       (lo_q),
    .ld_unsigned (uns_q),
    .mem_rdata   (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    mis_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (mis_d) begin
            mis_hit = 1'b1;
          end else begin
            start   = 1'b1;
            // Stall is combinational here, so keep it quiet while held in reset
            stall   = reset;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      is_load_q     <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= LD_BYTE;
      lo_q          <= 2'b00;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rdata_valid_q <= ack_hit & is_load_q;
      misaligned_q  <= mis_hit;
      bus_error_q   <= timeout_hit;

      if (start) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= is_store;
        mem_be_q    <= be_d;
        mem_addr_q  <= {cpu_addr[31:2], 2'b00};
        mem_wdata_q <= wdata_d;
        is_load_q   <= ~is_store;
        size_q      <= acc_size;
        uns_q       <= cpu_rd_unsigned;
        lo_q        <= cpu_addr[1:0];
      end else if (ack_hit || timeout_hit) begin
        mem_req_q <= 1'b0;
      end

      if (state_q == BUS && state_d == BUS) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      if (ack_hit && is_load_q) begin
        rdata_q <= ld_data;
      end else if (timeout_hit) begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
